// File: rtl/alu_result_checker.sv
// ----------------------------------------------------------------------------
// alu_result_checker
//
// Consumer-side response checker for the 8-bit ALU. Every accepted sample
// (operands, control code and the ALU's 17-bit result) travels through a
// two-stage pipeline: stage 1 registers the sample, stage 2 computes the
// expected result and the mismatch flag. Stage-2 outputs drive the sample
// and mismatch counters and the first-failure capture registers. When the
// programmed number of samples has been compared, the block reports
// pass/fail and holds its results until the next start.
//
// Parameters:
//   EXPECT_COUNT  samples checked per run (1 .. 2^19-1)
//   ERR_W         width of the mismatch counter
//
// Ports:
//   i_clk           clock
//   i_rst           synchronous active-high reset
//   i_start         start / restart a run (ignored while running)
//   i_valid         a sample is present this cycle
//   i_control       ALU operation code of the sample
//   i_a, i_b        ALU operands of the sample
//   i_out           ALU result under test
//   o_busy          run in progress
//   o_done          run complete, results held
//   o_pass          no mismatches (meaningful only with o_done)
//   o_sample_count  samples compared so far
//   o_err_count     mismatches so far, saturating
//   o_fail_*        first mismatching sample and its expected result
//   o_fail_seen     the o_fail_* registers hold a captured failure
// ----------------------------------------------------------------------------
module alu_result_checker #(
    parameter int EXPECT_COUNT = 262144,
    parameter int ERR_W        = 19
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [1:0]       i_control,
    input  logic [7:0]       i_a,
    input  logic [7:0]       i_b,
    input  logic [16:0]      i_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [18:0]      o_sample_count,
    output logic [ERR_W-1:0] o_err_count,
    output logic [1:0]       o_fail_control,
    output logic [7:0]       o_fail_a,
    output logic [7:0]       o_fail_b,
    output logic [16:0]      o_fail_out,
    output logic [16:0]      o_fail_exp,
    output logic             o_fail_seen
);

    localparam logic [18:0]      LIMIT   = 19'(EXPECT_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Control
    logic        start_clear;
    logic        accept;
    logic [18:0] accept_count;

    // Stage 1: registered sample
    logic        s1_valid;
    logic [1:0]  s1_control;
    logic [7:0]  s1_a;
    logic [7:0]  s1_b;
    logic [16:0] s1_out;

    // Expected value computed from stage 1
    logic [15:0] product;
    logic [16:0] exp_value;

    // Stage 2: registered sample, expected value and mismatch flag
    logic        s2_valid;
    logic [1:0]  s2_control;
    logic [7:0]  s2_a;
    logic [7:0]  s2_b;
    logic [16:0] s2_out;
    logic [16:0] s2_exp;
    logic        s2_mismatch;

    // Result registers
    logic [18:0]      sample_count;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       fail_control;
    logic [7:0]       fail_a;
    logic [7:0]       fail_b;
    logic [16:0]      fail_out;
    logic [16:0]      fail_exp;
    logic             fail_seen;

    // A start only counts outside RUN; it both clears results and launches
    // the next run on the same edge.
    assign start_clear = i_start && (state != RUN);

    // Acceptance stops once the limit is reached so nothing beyond the
    // programmed count ever enters the pipeline.
    assign accept = (state == RUN) && i_valid && (accept_count < LIMIT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // The run ends on compared (not accepted) samples, so the pipeline is
    // guaranteed to have drained when DONE is entered.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (sample_count == LIMIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_pass = 1'b0;
        case (state)
            RUN: begin
                o_busy = 1'b1;
            end
            DONE: begin
                o_done = 1'b1;
                o_pass = (err_count == '0);
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accepted-sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst || start_clear) begin
            accept_count <= '0;
        end else if (accept) begin
            accept_count <= accept_count + 19'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_control <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_out     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_control <= i_control;
                s1_a       <= i_a;
                s1_b       <= i_b;
                s1_out     <= i_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Expected ALU result. Operands are zero-extended before the operation,
    // so subtraction wraps modulo 2^17 (0 - 1 gives 17'h1FFFF).
    // ------------------------------------------------------------------
    always_comb begin
        product   = {8'b0, s1_a} * {8'b0, s1_b};
        exp_value = '0;
        case (s1_control)
            2'b00:   exp_value = {9'b0, s1_a} + {9'b0, s1_b};
            2'b01:   exp_value = {9'b0, s1_a} - {9'b0, s1_b};
            2'b10:   exp_value = {1'b0, product};
            default: exp_value = {9'b0, s1_a & s1_b};
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid    <= 1'b0;
            s2_control  <= '0;
            s2_a        <= '0;
            s2_b        <= '0;
            s2_out      <= '0;
            s2_exp      <= '0;
            s2_mismatch <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_control  <= s1_control;
                s2_a        <= s1_a;
                s2_b        <= s1_b;
                s2_out      <= s1_out;
                s2_exp      <= exp_value;
                s2_mismatch <= (exp_value != s1_out);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and first-failure capture. Only the first mismatch of a run
    // is captured; fail_seen locks the capture registers afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst || start_clear) begin
            sample_count <= '0;
            err_count    <= '0;
            fail_control <= '0;
            fail_a       <= '0;
            fail_b       <= '0;
            fail_out     <= '0;
            fail_exp     <= '0;
            fail_seen    <= 1'b0;
        end else if (s2_valid) begin
            sample_count <= sample_count + 19'd1;
            if (s2_mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (!fail_seen) begin
                    fail_control <= s2_control;
                    fail_a       <= s2_a;
                    fail_b       <= s2_b;
                    fail_out     <= s2_out;
                    fail_exp     <= s2_exp;
                    fail_seen    <= 1'b1;
                end
            end
        end
    end

    assign o_sample_count = sample_count;
    assign o_err_count    = err_count;
    assign o_fail_control = fail_control;
    assign o_fail_a       = fail_a;
    assign o_fail_b       = fail_b;
    assign o_fail_out     = fail_out;
    assign o_fail_exp     = fail_exp;
    assign o_fail_seen    = fail_seen;

endmodule

// File: tb/tb_alu_result_checker.sv
// ----------------------------------------------------------------------------
// tb_alu_result_checker
//
// Directed bench for alu_result_checker. Three instances share one stimulus
// bus and differ only in EXPECT_COUNT (300, 4 and 1), so long runs, the
// sample limit and the single-sample limit are all exercised with the same
// vectors. Each test resets first and checks only the instance it targets.
// ----------------------------------------------------------------------------
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        valid;
    logic [1:0]  control;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [16:0] out;

    always #5 clk = ~clk;

    // Instance with EXPECT_COUNT = 300
    logic        big_busy, big_done, big_pass, big_fail_seen;
    logic [18:0] big_sample_count, big_err_count;
    logic [1:0]  big_fail_control;
    logic [7:0]  big_fail_a, big_fail_b;
    logic [16:0] big_fail_out, big_fail_exp;

    // Instance with EXPECT_COUNT = 4
    logic        small_busy, small_done, small_pass, small_fail_seen;
    logic [18:0] small_sample_count, small_err_count;
    logic [1:0]  small_fail_control;
    logic [7:0]  small_fail_a, small_fail_b;
    logic [16:0] small_fail_out, small_fail_exp;

    // Instance with EXPECT_COUNT = 1
    logic        one_busy, one_done, one_pass, one_fail_seen;
    logic [18:0] one_sample_count, one_err_count;
    logic [1:0]  one_fail_control;
    logic [7:0]  one_fail_a, one_fail_b;
    logic [16:0] one_fail_out, one_fail_exp;

    alu_result_checker #(.EXPECT_COUNT(300), .ERR_W(19)) dut_big (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_control(control), .i_a(a), .i_b(b), .i_out(out),
        .o_busy(big_busy), .o_done(big_done), .o_pass(big_pass),
        .o_sample_count(big_sample_count), .o_err_count(big_err_count),
        .o_fail_control(big_fail_control), .o_fail_a(big_fail_a),
        .o_fail_b(big_fail_b), .o_fail_out(big_fail_out),
        .o_fail_exp(big_fail_exp), .o_fail_seen(big_fail_seen)
    );

    alu_result_checker #(.EXPECT_COUNT(4), .ERR_W(19)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_control(control), .i_a(a), .i_b(b), .i_out(out),
        .o_busy(small_busy), .o_done(small_done), .o_pass(small_pass),
        .o_sample_count(small_sample_count), .o_err_count(small_err_count),
        .o_fail_control(small_fail_control), .o_fail_a(small_fail_a),
        .o_fail_b(small_fail_b), .o_fail_out(small_fail_out),
        .o_fail_exp(small_fail_exp), .o_fail_seen(small_fail_seen)
    );

    alu_result_checker #(.EXPECT_COUNT(1), .ERR_W(19)) dut_one (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .i_control(control), .i_a(a), .i_b(b), .i_out(out),
        .o_busy(one_busy), .o_done(one_done), .o_pass(one_pass),
        .o_sample_count(one_sample_count), .o_err_count(one_err_count),
        .o_fail_control(one_fail_control), .o_fail_a(one_fail_a),
        .o_fail_b(one_fail_b), .o_fail_out(one_fail_out),
        .o_fail_exp(one_fail_exp), .o_fail_seen(one_fail_seen)
    );

    typedef struct {
        logic [1:0]  control;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] out;
        logic        exp_err;
        logic [16:0] exp_val;
    } vec_t;

    vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference ALU built on 32-bit integer arithmetic, truncated to 17 bits.
    function automatic logic [16:0] modelAlu(input logic [1:0] c,
                                             input logic [7:0] x,
                                             input logic [7:0] y);
        int r;
        case (c)
            2'b00:   r = int'(x) + int'(y);
            2'b01:   r = int'(x) - int'(y);
            2'b10:   r = int'(x) * int'(y);
            default: r = int'(x & y);
        endcase
        return r[16:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of sample inputs and advances to the next negedge.
    task automatic applyStimulus(input logic v, input logic [1:0] c,
                                 input logic [7:0] x, input logic [7:0] y,
                                 input logic [16:0] o);
        valid   = v;
        control = c;
        a       = x;
        b       = y;
        out     = o;
        tick();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 17'd0);
        end
    endtask

    task automatic doReset();
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [1:0]  c;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [16:0] o;

        vecs[0] = '{2'b01, 8'd0,   8'd1,   17'h1FFFF, 1'b0, 17'h1FFFF};
        vecs[1] = '{2'b01, 8'd0,   8'd1,   17'h0FFFF, 1'b1, 17'h1FFFF};
        vecs[2] = '{2'b00, 8'd255, 8'd255, 17'h001FE, 1'b0, 17'h001FE};
        vecs[3] = '{2'b10, 8'd255, 8'd255, 17'h0FE01, 1'b0, 17'h0FE01};
        vecs[4] = '{2'b11, 8'hF0,  8'h3C,  17'h00030, 1'b0, 17'h00030};
        vecs[5] = '{2'b00, 8'd1,   8'd1,   17'h00003, 1'b1, 17'h00002};
        vecs[6] = '{2'b10, 8'd16,  8'd16,  17'h00100, 1'b0, 17'h00100};
        vecs[7] = '{2'b01, 8'd5,   8'd3,   17'h00002, 1'b0, 17'h00002};
        vecs[8] = '{2'b11, 8'hAA,  8'h55,  17'h00001, 1'b1, 17'h00000};
        vecs[9] = '{2'b01, 8'd3,   8'd5,   17'h1FFFE, 1'b0, 17'h1FFFE};

        rst = 1'b0; start = 1'b0; valid = 1'b0;
        control = '0; a = '0; b = '0; out = '0;
        tick();

        // Reset state
        doReset();
        checkOutput("reset busy", 32'(big_busy), 32'd0);
        checkOutput("reset done", 32'(big_done), 32'd0);
        checkOutput("reset pass", 32'(big_pass), 32'd0);
        checkOutput("reset sample_count", 32'(big_sample_count), 32'd0);
        checkOutput("reset err_count", 32'(big_err_count), 32'd0);
        checkOutput("reset fail_seen", 32'(big_fail_seen), 32'd0);
        checkOutput("reset fail_exp", 32'(big_fail_exp), 32'd0);

        // Table vectors: one sample per run, result visible exactly two edges later
        for (int i = 0; i < 10; i++) begin
            doReset();
            pulseStart();
            applyStimulus(1'b1, vecs[i].control, vecs[i].a, vecs[i].b, vecs[i].out);
            idleCycles(1);
            checkOutput($sformatf("vec%0d count before latency", i), 32'(big_sample_count), 32'd0);
            idleCycles(1);
            checkOutput($sformatf("vec%0d sample_count", i), 32'(big_sample_count), 32'd1);
            checkOutput($sformatf("vec%0d err_count", i), 32'(big_err_count), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d fail_seen", i), 32'(big_fail_seen), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d fail_exp", i), 32'(big_fail_exp),
                        vecs[i].exp_err ? 32'(vecs[i].exp_val) : 32'd0);
            checkOutput($sformatf("vec%0d fail_out", i), 32'(big_fail_out),
                        vecs[i].exp_err ? 32'(vecs[i].out) : 32'd0);
            if (vecs[i].exp_err) begin
                checkOutput($sformatf("vec%0d fail_a", i), 32'(big_fail_a), 32'(vecs[i].a));
                checkOutput($sformatf("vec%0d fail_b", i), 32'(big_fail_b), 32'(vecs[i].b));
            end
        end

        // Sample presented in the same cycle as start is not accepted
        doReset();
        start = 1'b1;
        applyStimulus(1'b1, 2'b00, 8'd1, 8'd1, 17'd0);
        start = 1'b0;
        checkOutput("start-cycle busy", 32'(big_busy), 32'd1);
        idleCycles(3);
        checkOutput("start-cycle sample_count", 32'(big_sample_count), 32'd0);
        checkOutput("start-cycle err_count", 32'(big_err_count), 32'd0);

        // Six back-to-back samples: limit 4 and limit 1 instances
        doReset();
        pulseStart();
        for (int k = 0; k < 6; k++) begin
            c = 2'(k);
            x = 8'(k * 29 + 7);
            y = 8'(k * 53 + 2);
            o = modelAlu(c, x, y);
            if (k == 1) o = o ^ 17'h00010;
            applyStimulus(1'b1, c, x, y, o);
            if (k == 2) begin
                checkOutput("one done early", 32'(one_done), 32'd0);
                checkOutput("one sample_count", 32'(one_sample_count), 32'd1);
            end
            if (k == 3) begin
                checkOutput("one done", 32'(one_done), 32'd1);
                checkOutput("one pass", 32'(one_pass), 32'd1);
            end
            if (k == 5) begin
                checkOutput("small done early", 32'(small_done), 32'd0);
                checkOutput("small busy early", 32'(small_busy), 32'd1);
                checkOutput("small sample_count n+2", 32'(small_sample_count), 32'd4);
            end
        end
        idleCycles(1);
        checkOutput("small done n+3", 32'(small_done), 32'd1);
        checkOutput("small busy n+3", 32'(small_busy), 32'd0);
        checkOutput("small sample_count limit", 32'(small_sample_count), 32'd4);
        checkOutput("small err_count", 32'(small_err_count), 32'd1);
        checkOutput("small pass", 32'(small_pass), 32'd0);
        checkOutput("small fail_a", 32'(small_fail_a), 32'd36);
        idleCycles(3);
        checkOutput("small sample_count hold", 32'(small_sample_count), 32'd4);

        // Two mismatches: capture keeps the first
        doReset();
        pulseStart();
        applyStimulus(1'b1, 2'b10, 8'd255, 8'd255, 17'd0);
        applyStimulus(1'b1, 2'b00, 8'd1, 8'd1, 17'd3);
        applyStimulus(1'b1, 2'b11, 8'd0, 8'd0, 17'd0);
        applyStimulus(1'b1, 2'b00, 8'd2, 8'd3, 17'd5);
        valid = 1'b0;
        for (int k = 0; k < 20 && !small_done; k++) tick();
        checkOutput("two-err done", 32'(small_done), 32'd1);
        checkOutput("two-err err_count", 32'(small_err_count), 32'd2);
        checkOutput("two-err fail_exp", 32'(small_fail_exp), 32'h0FE01);
        checkOutput("two-err fail_control", 32'(small_fail_control), 32'd2);
        checkOutput("two-err fail_a", 32'(small_fail_a), 32'd255);
        checkOutput("two-err fail_out", 32'(small_fail_out), 32'd0);
        checkOutput("two-err pass", 32'(small_pass), 32'd0);

        // Start from DONE clears results
        pulseStart();
        checkOutput("restart busy", 32'(small_busy), 32'd1);
        checkOutput("restart done", 32'(small_done), 32'd0);
        checkOutput("restart sample_count", 32'(small_sample_count), 32'd0);
        checkOutput("restart err_count", 32'(small_err_count), 32'd0);
        checkOutput("restart fail_seen", 32'(small_fail_seen), 32'd0);
        checkOutput("restart fail_exp", 32'(small_fail_exp), 32'd0);

        // Start during RUN has no effect
        applyStimulus(1'b1, 2'b01, 8'd0, 8'd1, 17'h0FFFF);
        start = 1'b1;
        applyStimulus(1'b1, 2'b00, 8'd1, 8'd1, 17'd2);
        start = 1'b0;
        idleCycles(3);
        checkOutput("run-start sample_count", 32'(small_sample_count), 32'd2);
        checkOutput("run-start err_count", 32'(small_err_count), 32'd1);
        checkOutput("run-start busy", 32'(small_busy), 32'd1);

        // Reset mid-run discards in-flight samples
        doReset();
        pulseStart();
        for (int i = 0; i < 100; i++) begin
            c = 2'(i);
            x = 8'(i * 11);
            y = 8'(i * 7 + 1);
            o = modelAlu(c, x, y);
            if (i >= 98) o = o ^ 17'h00001;
            applyStimulus(1'b1, c, x, y, o);
        end
        checkOutput("pre-reset sample_count", 32'(big_sample_count), 32'd98);
        checkOutput("pre-reset err_count", 32'(big_err_count), 32'd0);
        doReset();
        checkOutput("mid-reset busy", 32'(big_busy), 32'd0);
        checkOutput("mid-reset sample_count", 32'(big_sample_count), 32'd0);
        idleCycles(3);
        checkOutput("post-reset sample_count", 32'(big_sample_count), 32'd0);
        checkOutput("post-reset err_count", 32'(big_err_count), 32'd0);
        checkOutput("post-reset fail_seen", 32'(big_fail_seen), 32'd0);

        // Clean rerun: 300 correct samples with gaps
        pulseStart();
        for (int i = 0; i < 300; i++) begin
            c = 2'(i);
            x = 8'((i * 37 + 5) & 255);
            y = 8'((i * 91 + 13) & 255);
            if (i == 1)   begin x = 8'd0; y = 8'd1; end
            if (i == 2)   begin x = 8'd255; y = 8'd255; end
            applyStimulus(1'b1, c, x, y, modelAlu(c, x, y));
            if (i % 50 == 49) idleCycles(2);
        end
        valid = 1'b0;
        for (int k = 0; k < 20 && !big_done; k++) tick();
        checkOutput("sweep done", 32'(big_done), 32'd1);
        checkOutput("sweep pass", 32'(big_pass), 32'd1);
        checkOutput("sweep sample_count", 32'(big_sample_count), 32'd300);
        checkOutput("sweep err_count", 32'(big_err_count), 32'd0);
        checkOutput("sweep fail_seen", 32'(big_fail_seen), 32'd0);
        applyStimulus(1'b1, 2'b00, 8'd1, 8'd1, 17'd9);
        idleCycles(3);
        checkOutput("done ignores samples", 32'(big_sample_count), 32'd300);
        checkOutput("done holds pass", 32'(big_pass), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable response checker for the 8-bit ALU (`i_a`, `i_b`, `i_control[1:0]` → `o_out[16:0]`). It sits on the consumer side of the ALU and receives one sample per valid cycle: the operands, the control code and the ALU's 17-bit result. For each sample it computes the expected result in a two-stage pipeline, compares it with the ALU result, counts samples and mismatches, and captures the first failing vector. It reports pass/fail once a programmed number of samples has been checked, so an exhaustive operand sweep can be judged on hardware with no simulator console.

## Interface
Parameters:
- `EXPECT_COUNT`, default 262144 (4 × 65536): number of samples checked before the run completes; legal range 1 to 2^19−1.
- `ERR_W`, default 19: width of the mismatch counter.

Ports:
- `i_clk`  in  1  clock; the only clock.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_start`  in  1  start or restart a run (single-cycle pulse).
- `i_valid`  in  1  a sample is present on `i_control`, `i_a`, `i_b` and `i_out` this cycle.
- `i_control`  in  2  ALU operation code of the sample.
- `i_a`, `i_b`  in  8 each  ALU operands of the sample.
- `i_out`  in  17  ALU result under test.
- `o_busy`  out  1  high while in RUN.
- `o_done`  out  1  high while in DONE.
- `o_pass`  out  1  valid only when `o_done`=1; high when the mismatch count is 0.
- `o_sample_count`  out  19  number of samples compared so far.
- `o_err_count`  out  `ERR_W`  number of mismatches; saturates at all-ones.
- `o_fail_control`  out  2, `o_fail_a`  out  8, `o_fail_b`  out  8, `o_fail_out`  out  17, `o_fail_exp`  out  17  the first mismatching sample and its expected value.
- `o_fail_seen`  out  1  the `o_fail_*` outputs hold a captured failure.

## Operation
- Expected result, all arithmetic 17 bits wide, unsigned:
  - 00: `{9'b0,a} + {9'b0,b}`.
  - 01: `{9'b0,a} − {9'b0,b}` modulo 2^17. Example: 0 − 1 = 17'h1FFFF.
  - 10: `a × b` zero-extended to 17 bits.
  - 11: `{9'b0, a & b}`.
- States:
  - IDLE: samples are ignored. `i_start` clears every counter, `o_fail_seen` and all capture registers, then moves to RUN.
  - RUN: each cycle with `i_valid`=1 is accepted until the accepted count reaches `EXPECT_COUNT`; further samples are ignored. When the compared count reaches `EXPECT_COUNT`, the block moves to DONE.
  - DONE: holds all results and ignores samples. `i_start` performs the same clear as in IDLE and moves to RUN.
- `i_start` while in RUN is ignored. There is no abort; use `i_rst`.
- Pipeline:
  - Stage 1 registers the accepted sample and a valid bit.
  - Stage 2 computes the expected value and registers the sample, the expected value and the mismatch flag.
  - The counter and capture update happens from the stage-2 outputs.
- Mismatch handling: a mismatch increments `o_err_count`, saturating at all-ones. If `o_fail_seen`=0, the sample and its expected value are loaded into the `o_fail_*` registers and `o_fail_seen` is set. Later mismatches do not overwrite the capture.
- `o_pass` = `(o_err_count == 0)`, qualified by `o_done`.

## Timing
- Reset values, one cycle after `i_rst` is sampled high: state IDLE, `o_busy`=0, `o_done`=0, `o_pass`=0, all counts 0, all `o_fail_*` 0, `o_fail_seen`=0, pipeline valid bits 0.
- Reset has priority over `i_start` and `i_valid` in the same cycle.
- Reset during RUN discards in-flight samples and returns the block to IDLE.
- `i_start` at edge t: `o_busy`=1 from t+1. A sample with `i_valid` at t is not accepted; the first acceptable sample is at t+1.
- A sample accepted at edge n updates `o_sample_count`, `o_err_count` and the failure capture so they are visible after edge n+2 (latency 2).
- The last sample, accepted at edge n: `o_busy` falls and `o_done` rises after edge n+3. No sample is lost in the pipeline.
- Throughput: one sample per cycle. `i_valid` gaps are allowed anywhere.
- `EXPECT_COUNT`=1: the accepted-count limit is reached after one sample; the block still waits for that sample to drain.

## Test plan
- Reset, then `i_start`, then exhaustive sweep (control 0–3, a and b 0–255 each) with a correct ALU model → `o_done`=1, `o_pass`=1, `o_sample_count`=262144, `o_err_count`=0, `o_fail_seen`=0.
- Control 01, a=0, b=1, `i_out`=17'h1FFFF → no mismatch. Same sample with `i_out`=17'h0FFFF → `o_err_count`=1 two cycles later; `o_fail_exp`=17'h1FFFF, `o_fail_a`=0, `o_fail_b`=1.
- Two mismatches: (10, a=255, b=255, out=0), then (00, a=1, b=1, out=3) → `o_err_count`=2; capture holds the first (`o_fail_exp`=17'h0FE01). At done, `o_pass`=0.
- `EXPECT_COUNT`=4 with 6 back-to-back valid samples → only 4 counted; `o_done` asserts 3 cycles after the 4th sample is accepted.
- `i_rst` asserted mid-run after 100 samples → next cycle: IDLE, all counts 0. A later `i_start` re-runs cleanly.
- `i_start` pulse in DONE → counts and capture clear, `o_busy`=1 next cycle. An `i_start` pulse in RUN → no effect on the counts.
